gpio_controller: RTL and testbench
==================================

GPIO_CONTROLLER -- requirements
Module: gpio_controller

Interface
REQ-001 SHALL have parameter: NUM_BANKS, default 8, number of 32-bit GPIO banks (legal 1..8); pin count N = 32*NUM_BANKS.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: paddr  input  11  APB byte address; bits [1:0] ignored.
REQ-005 SHALL have ports: pwrite, psel, penable  input  1 each  APB control.
REQ-006 SHALL have ports: pstrb  input  4  write byte strobes; pwdata  input  32  write data.
REQ-007 SHALL have ports: prdata  output  32  read data; pready  output  1  ready; pslverr  output  1  error.
REQ-008 SHALL have port: interrupt  output  1  level interrupt, OR of all INT_STATUS bits.
REQ-009 SHALL have ports: gpio_in_data  input  N  pin inputs (asynchronous); gpio_out_data  output  N  pin output values; gpio_out_enable  output  N  per-pin output drive enable.

Function
REQ-010 SHALL use the register map, bank b at offset 4*b:
- 0x000+4b GPIO_OUT RW
- 0x100+4b GPIO_OE RW
- 0x200+4b GPIO_IN RO
- 0x300+4b RISE_IE RW
- 0x400+4b FALL_IE RW
- 0x500 INT_STATUS, bit b = bank b event, W1C.
REQ-011 SHALL complete every transfer with zero wait states: pready constantly 1.
REQ-012 SHALL perform a write only in the access phase (psel & penable & pwrite), updating only bytes whose pstrb bit is 1.
REQ-013 SHALL drive prdata combinationally from paddr whenever psel & ~pwrite; unused bits and unmapped addresses read 0.
REQ-014 SHALL assert pslverr during the access phase for unmapped addresses (including bank index >= NUM_BANKS) and for writes to GPIO_IN; such writes SHALL have no effect.
REQ-015 SHALL drive gpio_out_data and gpio_out_enable directly from the GPIO_OUT and GPIO_OE registers, updating on the write edge.
REQ-016 SHALL pass gpio_in_data through a 2-flop synchronizer; GPIO_IN reads the synchronizer output.
REQ-017 SHALL keep a registered copy (prev) of the synchronized input; rise = sync & ~prev; fall = ~sync & prev.
REQ-018 SHALL set INT_STATUS[b] on the edge after any pin in bank b has (rise & RISE_IE) | (fall & FALL_IE).
- Total latency from a pin change to interrupt high: 3 clock edges.
REQ-019 SHALL hold INT_STATUS bits until software writes 1 to them (pstrb[0] gating); writing 0 has no effect.
REQ-020 SHALL give a new event priority over a same-cycle W1C clear, so the bit stays set.
REQ-021 SHALL NOT set a status bit when an interrupt enable is written while the pin is already at the new level; only edges count.
REQ-022 SHALL NOT affect already-set status bits when enables are cleared.

Reset
REQ-023 SHALL, on rst_n low, clear all state asynchronously: GPIO_OUT, GPIO_OE, RISE_IE, FALL_IE, INT_STATUS, the synchronizer and prev all become 0.
- Outputs then read: gpio_out_data=0, gpio_out_enable=0, interrupt=0, pslverr=0.
REQ-024 SHALL resume normal operation on the first clock edge after rst_n deasserts.

Configuration
REQ-025 SHALL compile the falling-edge interrupt logic only when macro GPIO_FALL_IRQ_EN is defined.
- Without it: FALL_IE reads 0, writes there are ignored without error, and falling edges never set status.

Verification
REQ-026 Write 0x12345678 to 0x000, pstrb=0xF -> gpio_out_data[31:0]=0x12345678, pslverr=0.
REQ-027 gpio_in_data=0x90abcdef_00000000, read 0x204 -> prdata=0x90abcdef.
REQ-028 All IE=0, bit 64 goes 0->1 -> INT_STATUS=0 and interrupt stays 0.
REQ-029 Write 0xFFFFFFFF to 0x308, then bit 65 rises -> interrupt=1 within 3 cycles; read 0x500 -> 0x00000004.
REQ-030 Write 0x00000004 to 0x500 -> INT_STATUS=0, interrupt=0; a W1C write in the same cycle as a new event leaves the bit at 1.
REQ-031 Read 0x600 -> pslverr=1, prdata=0; write 0x200 -> pslverr=1, state unchanged.

Source files
------------

// File: rtl/gpio_controller.sv
// GPIO controller: NUM_BANKS x 32-bit banks behind a zero-wait-state APB slave,
// with per-pin output/enable registers, synchronized inputs and edge interrupts.
// Optional feature macro: GPIO_FALL_IRQ_EN enables falling-edge interrupt logic.
module gpio_controller #(
    parameter int unsigned NUM_BANKS = 8,
    localparam int unsigned PIN_W = 32 * NUM_BANKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      paddr,
    input  logic             pwrite,
    input  logic             psel,
    input  logic             penable,
    input  logic [3:0]       pstrb,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    output logic             pready,
    output logic             pslverr,
    output logic             interrupt,
    input  logic [PIN_W-1:0] gpio_in_data,
    output logic [PIN_W-1:0] gpio_out_data,
    output logic [PIN_W-1:0] gpio_out_enable
);

    localparam int unsigned BANK_W = 32;

    localparam logic [2:0] REG_OUT  = 3'd0;
    localparam logic [2:0] REG_OE   = 3'd1;
    localparam logic [2:0] REG_IN   = 3'd2;
    localparam logic [2:0] REG_RISE = 3'd3;
    localparam logic [2:0] REG_FALL = 3'd4;
    localparam logic [2:0] REG_INT  = 3'd5;

    logic [NUM_BANKS-1:0][BANK_W-1:0] out_q;
    logic [NUM_BANKS-1:0][BANK_W-1:0] oe_q;
    logic [NUM_BANKS-1:0][BANK_W-1:0] rise_ie_q;
    logic [NUM_BANKS-1:0][BANK_W-1:0] fall_ie_q;
    logic [NUM_BANKS-1:0][BANK_W-1:0] sync1_q;
    logic [NUM_BANKS-1:0][BANK_W-1:0] sync_q;
    logic [NUM_BANKS-1:0][BANK_W-1:0] prev_q;
    logic [NUM_BANKS-1:0]             int_status_q;

    logic [2:0]           region;
    logic [5:0]           bank_idx;
    logic                 bank_ok;
    logic                 mapped;
    logic                 addr_err;
    logic                 wr_en;
    logic [NUM_BANKS-1:0] bank_event;
    logic [NUM_BANKS-1:0] int_clear;
    logic                 unused_addr_lsbs;

    assign region           = paddr[10:8];
    assign bank_idx         = paddr[7:2];
    assign unused_addr_lsbs = &{1'b0, paddr[1:0]};

    // Merge write data into a register under byte strobes.
    function automatic logic [BANK_W-1:0] merge_bytes(input logic [BANK_W-1:0] cur,
                                                      input logic [31:0]       wdata,
                                                      input logic [3:0]        strb);
        logic [BANK_W-1:0] merged;
        merged = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return merged;
    endfunction

    // Address decode: bank registers need a real bank, INT_STATUS is a single word.
    always_comb begin
        bank_ok = (32'(bank_idx) < NUM_BANKS);
        mapped  = 1'b0;
        case (region)
            REG_OUT, REG_OE, REG_IN, REG_RISE, REG_FALL: mapped = bank_ok;
            REG_INT:                                     mapped = (bank_idx == 6'd0);
            default:                                     mapped = 1'b0;
        endcase
        addr_err = !mapped || (pwrite && (region == REG_IN));
    end

    assign pready  = 1'b1;
    assign pslverr = psel && penable && addr_err;
    assign wr_en   = psel && penable && pwrite && !addr_err;

    // Combinational read mux; unmapped locations read zero.
    always_comb begin
        prdata = '0;
        if (psel && !pwrite && mapped) begin
            if (region == REG_INT) begin
                prdata = 32'(int_status_q);
            end else begin
                for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                    if (bank_idx == 6'(b)) begin
                        case (region)
                            REG_OUT:  prdata = out_q[b];
                            REG_OE:   prdata = oe_q[b];
                            REG_IN:   prdata = sync_q[b];
                            REG_RISE: prdata = rise_ie_q[b];
                            REG_FALL: prdata = fall_ie_q[b];
                            default:  prdata = '0;
                        endcase
                    end
                end
            end
        end
    end

    // Software-writable bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_ie_q <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (bank_idx == 6'(b)) begin
                    case (region)
                        REG_OUT:  out_q[b]     <= merge_bytes(out_q[b], pwdata, pstrb);
                        REG_OE:   oe_q[b]      <= merge_bytes(oe_q[b], pwdata, pstrb);
                        REG_RISE: rise_ie_q[b] <= merge_bytes(rise_ie_q[b], pwdata, pstrb);
                        default:  ;
                    endcase
                end
            end
        end
    end

`ifdef GPIO_FALL_IRQ_EN
    // Falling-edge enables, present only when the feature is built in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_ie_q <= '0;
        end else if (wr_en && (region == REG_FALL)) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (bank_idx == 6'(b)) fall_ie_q[b] <= merge_bytes(fall_ie_q[b], pwdata, pstrb);
            end
        end
    end
`else
    assign fall_ie_q = '0;
`endif

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= gpio_in_data;
            sync_q  <= sync1_q;
            prev_q  <= sync_q;
        end
    end

    // Per-bank event: any enabled edge on any pin of the bank.
    always_comb begin
        bank_event = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
`ifdef GPIO_FALL_IRQ_EN
            bank_event[b] = |((sync_q[b] & ~prev_q[b] & rise_ie_q[b]) |
                              (~sync_q[b] & prev_q[b] & fall_ie_q[b]));
`else
            bank_event[b] = |(sync_q[b] & ~prev_q[b] & rise_ie_q[b]);
`endif
        end
        int_clear = '0;
        if (wr_en && (region == REG_INT)) begin
            int_clear = pwdata[NUM_BANKS-1:0] & {NUM_BANKS{pstrb[0]}};
        end
    end

    // Sticky status: a new event wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_status_q <= '0;
        end else begin
            int_status_q <= (int_status_q & ~int_clear) | bank_event;
        end
    end

    assign interrupt       = |int_status_q;
    assign gpio_out_data   = out_q;
    assign gpio_out_enable = oe_q;

endmodule

// File: tb/tb_gpio_controller.sv
// Directed, scoreboard-driven bench for gpio_controller (default NUM_BANKS = 8).
module tb_gpio_controller;

    logic         clk;
    logic         rst_n;
    logic [10:0]  paddr;
    logic         pwrite;
    logic         psel;
    logic         penable;
    logic [3:0]   pstrb;
    logic [31:0]  pwdata;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;
    logic         interrupt;
    logic [255:0] gpio_in;
    logic [255:0] gpio_out_data;
    logic [255:0] gpio_out_enable;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    gpio_controller #(.NUM_BANKS(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .paddr           (paddr),
        .pwrite          (pwrite),
        .psel            (psel),
        .penable         (penable),
        .pstrb           (pstrb),
        .pwdata          (pwdata),
        .prdata          (prdata),
        .pready          (pready),
        .pslverr         (pslverr),
        .interrupt       (interrupt),
        .gpio_in_data    (gpio_in),
        .gpio_out_data   (gpio_out_data),
        .gpio_out_enable (gpio_out_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_pop(obs);
    endtask

    task automatic apb_write(input logic [10:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic exp_err);
        paddr = a; pwdata = d; pstrb = s; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        sb_push($sformatf("wr_err_%03h", a), 32'(exp_err));
        @(posedge clk); #1;
        penable = 1'b1;
        #3;
        sb_pop(32'(pslverr));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [10:0] a, input logic [31:0] exp_d, input logic exp_err);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        sb_push($sformatf("rd_data_%03h", a), exp_d);
        sb_push($sformatf("rd_err_%03h", a), 32'(exp_err));
        @(posedge clk); #1;
        penable = 1'b1;
        #3;
        sb_pop(prdata);
        sb_pop(32'(pslverr));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; paddr = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
        pstrb = '0; pwdata = '0; gpio_in = '0;
        #1;
        check_now("rst_out",  gpio_out_data[31:0], 32'h0);
        check_now("rst_oe",   gpio_out_enable[255:224], 32'h0);
        check_now("rst_irq",  32'(interrupt), 32'h0);
        check_now("rst_err",  32'(pslverr), 32'h0);
        check_now("pready",   32'(pready), 32'h1);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);

        // Full and partial byte writes to GPIO_OUT bank 0
        apb_write(11'h000, 32'h12345678, 4'hF, 1'b0);
        check_now("out_full", gpio_out_data[31:0], 32'h12345678);
        apb_write(11'h000, 32'hAABBCCDD, 4'b0101, 1'b0);
        check_now("out_strb", gpio_out_data[31:0], 32'h12BB56DD);
        apb_read(11'h000, 32'h12BB56DD, 1'b0);

        // Output enable on the last bank
        apb_write(11'h11C, 32'hFFFF0000, 4'hF, 1'b0);
        check_now("oe_b7", gpio_out_enable[255:224], 32'hFFFF0000);
        apb_read(11'h11C, 32'hFFFF0000, 1'b0);

        // Synchronized input read
        gpio_in[63:32] = 32'h90abcdef;
        wait_cycles(3);
        apb_read(11'h204, 32'h90abcdef, 1'b0);

        // Edge with no enables does nothing
        gpio_in[64] = 1'b1;
        wait_cycles(5);
        check_now("noie_irq", 32'(interrupt), 32'h0);
        apb_read(11'h500, 32'h0, 1'b0);

        // Rising-edge interrupt, exact 3-edge latency
        apb_write(11'h308, 32'hFFFFFFFF, 4'hF, 1'b0);
        gpio_in[65] = 1'b1;
        wait_cycles(1);
        check_now("lat_e1", 32'(interrupt), 32'h0);
        wait_cycles(1);
        check_now("lat_e2", 32'(interrupt), 32'h0);
        wait_cycles(1);
        check_now("lat_e3", 32'(interrupt), 32'h1);
        apb_read(11'h500, 32'h00000004, 1'b0);

        // W1C clear
        apb_write(11'h500, 32'h00000004, 4'hF, 1'b0);
        check_now("w1c_irq", 32'(interrupt), 32'h0);
        apb_read(11'h500, 32'h0, 1'b0);

        // New event coincides with W1C write edge: bit stays set
        gpio_in[66] = 1'b1;
        wait_cycles(1);
        apb_write(11'h500, 32'h00000004, 4'hF, 1'b0);
        check_now("prio_irq", 32'(interrupt), 32'h1);
        apb_read(11'h500, 32'h00000004, 1'b0);

        // W1C without pstrb[0] has no effect; then a real clear
        apb_write(11'h500, 32'h00000004, 4'hE, 1'b0);
        apb_read(11'h500, 32'h00000004, 1'b0);
        apb_write(11'h500, 32'h00000000, 4'hF, 1'b0);
        apb_read(11'h500, 32'h00000004, 1'b0);
        apb_write(11'h500, 32'h00000004, 4'hF, 1'b0);
        apb_read(11'h500, 32'h0, 1'b0);

        // Clearing enables keeps an already-set status bit
        gpio_in[67] = 1'b1;
        wait_cycles(4);
        apb_write(11'h308, 32'h0, 4'hF, 1'b0);
        apb_read(11'h500, 32'h00000004, 1'b0);
        apb_write(11'h500, 32'h00000004, 4'hF, 1'b0);

        // Enabling while pin is already high is not an edge
        apb_write(11'h308, 32'hFFFFFFFF, 4'hF, 1'b0);
        wait_cycles(4);
        apb_read(11'h500, 32'h0, 1'b0);

        // Falling edges: count only when the feature is built in
        apb_write(11'h408, 32'hFFFFFFFF, 4'hF, 1'b0);
`ifdef GPIO_FALL_IRQ_EN
        apb_read(11'h408, 32'hFFFFFFFF, 1'b0);
`else
        apb_read(11'h408, 32'h0, 1'b0);
`endif
        gpio_in[67:64] = 4'h0;
        wait_cycles(4);
`ifdef GPIO_FALL_IRQ_EN
        apb_read(11'h500, 32'h00000004, 1'b0);
        apb_write(11'h500, 32'h00000004, 4'hF, 1'b0);
`else
        apb_read(11'h500, 32'h0, 1'b0);
`endif

        // Error responses
        apb_read(11'h600, 32'h0, 1'b1);
        apb_read(11'h504, 32'h0, 1'b1);
        apb_write(11'h200, 32'hFFFFFFFF, 4'hF, 1'b1);
        apb_read(11'h200, 32'h0, 1'b0);
        apb_write(11'h020, 32'hFFFFFFFF, 4'hF, 1'b1);
        apb_read(11'h020, 32'h0, 1'b1);
        check_now("err_nowr", gpio_out_data[31:0], 32'h12BB56DD);
        apb_read(11'h204, 32'h90abcdef, 1'b0);

        // Asynchronous reset mid-run clears state
        gpio_in[68] = 1'b1;
        wait_cycles(4);
        check_now("pre_rst_irq", 32'(interrupt), 32'h1);
        rst_n = 1'b0;
        #1;
        check_now("arst_out", gpio_out_data[31:0], 32'h0);
        check_now("arst_oe",  gpio_out_enable[255:224], 32'h0);
        check_now("arst_irq", 32'(interrupt), 32'h0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        apb_read(11'h308, 32'h0, 1'b0);

        check_now("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
